// File: rtl/dm_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// dm_responder_if : request/response bundle between the M stage and data memory
// Revision 1.0
//------------------------------------------------------------------------------
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byteEn;
  logic [2:0]  req_sel_ld;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wdata, req_byteEn, req_sel_ld,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_byteEn, req_sel_ld,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// dm_responder : single-outstanding data-memory responder with byte-enabled
//                stores, extended loads and programmable response latency
// Revision 1.0
//------------------------------------------------------------------------------
module dm_responder #(
  parameter int DEPTH = 3072,
  parameter int LAT   = 1
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);

  localparam int          IDXW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(longint'(DEPTH) * 4);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_q [DEPTH];

  logic            accept;
  logic            in_range;
  logic            is_store;
  logic            is_load;
  logic            store_ok;
  logic            load_ok;
  logic            wr_en;
  logic [IDXW-1:0] idx;
  logic [31:0]     rd_word;
  logic [31:0]     ld_data;
  logic [31:0]     be_mask;
  logic [31:0]     wr_word;
  logic [15:0]     half;
  logic [7:0]      lane_byte;

  assign bus.req_ready = (state_q == ST_IDLE) && !reset;
  assign bus.rsp_valid = (state_q == ST_BUSY) && (cnt_q == 4'd0) && !reset;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign accept        = bus.req_valid && bus.req_ready;

  // Request decode: legality, load extraction and the merged store word.
  always_comb begin
    idx       = bus.req_addr[IDXW+1:2];
    in_range  = {1'b0, bus.req_addr} < ADDR_LIMIT;
    rd_word   = mem_q[idx];
    is_store  = |bus.req_byteEn;
    is_load   = !is_store && (bus.req_sel_ld >= 3'd1) && (bus.req_sel_ld <= 3'd5);
    half      = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    lane_byte = rd_word[7:0];
    case (bus.req_addr[1:0])
      2'd1:    lane_byte = rd_word[15:8];
      2'd2:    lane_byte = rd_word[23:16];
      2'd3:    lane_byte = rd_word[31:24];
      default: lane_byte = rd_word[7:0];
    endcase

    store_ok = 1'b0;
    case (bus.req_byteEn)
      4'b1111:          store_ok = (bus.req_addr[1:0] == 2'b00);
      4'b0011, 4'b1100: store_ok = (bus.req_addr[1] == bus.req_byteEn[2]) && !bus.req_addr[0];
      4'b0001:          store_ok = (bus.req_addr[1:0] == 2'd0);
      4'b0010:          store_ok = (bus.req_addr[1:0] == 2'd1);
      4'b0100:          store_ok = (bus.req_addr[1:0] == 2'd2);
      4'b1000:          store_ok = (bus.req_addr[1:0] == 2'd3);
      default:          store_ok = 1'b0;
    endcase

    load_ok = 1'b0;
    ld_data = '0;
    case (bus.req_sel_ld)
      3'd1: begin
        load_ok = (bus.req_addr[1:0] == 2'b00);
        ld_data = rd_word;
      end
      3'd2: begin
        load_ok = !bus.req_addr[0];
        ld_data = {{16{half[15]}}, half};
      end
      3'd3: begin
        load_ok = !bus.req_addr[0];
        ld_data = {16'h0000, half};
      end
      3'd4: begin
        load_ok = 1'b1;
        ld_data = {{24{lane_byte[7]}}, lane_byte};
      end
      3'd5: begin
        load_ok = 1'b1;
        ld_data = {24'h000000, lane_byte};
      end
      default: begin
        load_ok = 1'b0;
        ld_data = '0;
      end
    endcase

    be_mask = {{8{bus.req_byteEn[3]}}, {8{bus.req_byteEn[2]}},
               {8{bus.req_byteEn[1]}}, {8{bus.req_byteEn[0]}}};
    wr_word = (rd_word & ~be_mask) | (bus.req_wdata & be_mask);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wr_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_BUSY;
          cnt_d       = 4'(LAT - 1);
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          if (is_store) begin
            if (in_range && store_ok) wr_en = 1'b1;
            else                      rsp_err_d = 1'b1;
          end else if (is_load) begin
            if (in_range && load_ok) rsp_rdata_d = ld_data;
            else                     rsp_err_d   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // One register per word so the whole array clears on reset.
  for (genvar w = 0; w < DEPTH; w++) begin : g_mem
    always_ff @(posedge clk) begin
      if (reset)                            mem_q[w] <= '0;
      else if (wr_en && (idx == IDXW'(w))) mem_q[w] <= wr_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_dm_responder : two responders (LAT=1 full depth, LAT=3 small depth)
//                   checked against a byte-level reference memory model
// Revision 1.0
//------------------------------------------------------------------------------
module tb_dm_responder;

  localparam int D1 = 3072;
  localparam int D3 = 64;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  longint cyc = 0;

  dm_responder_if bus1 ();
  dm_responder_if bus3 ();

  dm_responder #(.DEPTH(D1), .LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dm_responder #(.DEPTH(D3), .LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m1 [int];
  logic [31:0] m3 [int];

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  be;
    logic [2:0]  sel;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  function automatic logic rdy(input int d);
    return (d == 1) ? bus1.req_ready : bus3.req_ready;
  endfunction
  function automatic logic rv(input int d);
    return (d == 1) ? bus1.rsp_valid : bus3.rsp_valid;
  endfunction
  function automatic logic [31:0] rdat(input int d);
    return (d == 1) ? bus1.rsp_rdata : bus3.rsp_rdata;
  endfunction
  function automatic logic rerr(input int d);
    return (d == 1) ? bus1.rsp_err : bus3.rsp_err;
  endfunction

  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] be, input logic [2:0] sel);
    if (d == 1) begin
      bus1.req_valid = v; bus1.req_addr = a; bus1.req_wdata = w;
      bus1.req_byteEn = be; bus1.req_sel_ld = sel;
    end else begin
      bus3.req_valid = v; bus3.req_addr = a; bus3.req_wdata = w;
      bus3.req_byteEn = be; bus3.req_sel_ld = sel;
    end
  endtask

  function automatic logic [31:0] mread(input int d, input int i);
    if (d == 1) return m1.exists(i) ? m1[i] : 32'h0;
    return m3.exists(i) ? m3[i] : 32'h0;
  endfunction

  function automatic void mwrite(input int d, input int i, input logic [31:0] v);
    if (d == 1) m1[i] = v;
    else        m3[i] = v;
  endfunction

  // Reference: naturally aligned accesses of 1/2/4 bytes on a byte-addressed memory.
  function automatic void model(input int d, input logic [31:0] a, input logic [31:0] w,
                                input logic [3:0] be, input logic [2:0] sel,
                                output logic [31:0] er, output logic ee);
    longint lim = 4 * longint'((d == 1) ? D1 : D3);
    int off = int'(a % 4);
    int i   = int'(a / 4);
    int sz, ln;
    logic ok_range = (longint'(a) < lim);
    logic [31:0] word, v;
    er = 32'h0;
    ee = 1'b0;
    if (be != 4'b0000) begin
      sz = 0; ln = 0;
      case (be)
        4'b1111: begin sz = 4; ln = 0; end
        4'b0011: begin sz = 2; ln = 0; end
        4'b1100: begin sz = 2; ln = 2; end
        4'b0001: begin sz = 1; ln = 0; end
        4'b0010: begin sz = 1; ln = 1; end
        4'b0100: begin sz = 1; ln = 2; end
        4'b1000: begin sz = 1; ln = 3; end
        default: sz = 0;
      endcase
      if (!ok_range || sz == 0 || off != ln) ee = 1'b1;
      else begin
        word = mread(d, i);
        for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = w[8*b +: 8];
        mwrite(d, i, word);
      end
    end else if (sel >= 3'd1 && sel <= 3'd5) begin
      sz = (sel == 3'd1) ? 4 : (sel <= 3'd3) ? 2 : 1;
      if (!ok_range || (off % sz) != 0) ee = 1'b1;
      else begin
        v = mread(d, i) >> (8 * off);
        if (sz == 4) er = v;
        else if (sz == 2) er = (sel == 3'd2 && v[15]) ? (v & 32'hFFFF) | 32'hFFFF0000 : v & 32'hFFFF;
        else              er = (sel == 3'd4 && v[7])  ? (v & 32'hFF) | 32'hFFFFFF00   : v & 32'hFF;
      end
    end
  endfunction

  // Enters and leaves just after a rising edge.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be,
                     input logic [2:0] sel, output logic [31:0] act_r, output logic act_e);
    int lat = (d == 1) ? 1 : 3;
    int n = 0;
    int k = 0;
    logic [31:0] er;
    logic ee;
    drive(d, 1'b1, a, w, be, sel);
    while (rdy(d) !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    model(d, a, w, be, sel, er, ee);
    @(posedge clk); #1;
    drive(d, 1'b0, a, w, be, sel);
    while (rv(d) !== 1'b1 && k < 40) begin @(posedge clk); #1; k++; end
    checks++;
    if (k != lat - 1) begin errors++; $display("FAIL latency d=%0d addr=%h: got %0d want %0d", d, a, k, lat - 1); end
    checks++;
    if (rdy(d) !== 1'b0) begin errors++; $display("FAIL ready_in_rsp d=%0d: got %b want 0", d, rdy(d)); end
    act_r = rdat(d);
    act_e = rerr(d);
    checks++;
    if (act_r !== er) begin errors++; $display("FAIL rdata d=%0d addr=%h be=%b sel=%0d: got %h want %h", d, a, be, sel, act_r, er); end
    checks++;
    if (act_e !== ee) begin errors++; $display("FAIL err d=%0d addr=%h be=%b sel=%0d: got %b want %b", d, a, be, sel, act_e, ee); end
    @(posedge clk); #1;
    checks++;
    if (rv(d) !== 1'b0 || rdy(d) !== 1'b1) begin
      errors++; $display("FAIL after_rsp d=%0d: valid=%b ready=%b want 0/1", d, rv(d), rdy(d));
    end
    checks++;
    if (rdat(d) !== act_r || rerr(d) !== act_e) begin
      errors++; $display("FAIL hold d=%0d: rdata=%h err=%b want %h/%b", d, rdat(d), rerr(d), act_r, act_e);
    end
  endtask

  task automatic test_reset();
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    drive(3, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus1.req_ready !== 1'b0 || bus3.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b/%b want 0/0", bus1.req_ready, bus3.req_ready);
    end
    checks++;
    if (bus1.rsp_valid !== 1'b0 || bus1.rsp_rdata !== 32'h0 || bus1.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: valid=%b rdata=%h err=%b want 0/0/0", bus1.rsp_valid, bus1.rsp_rdata, bus1.rsp_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus1.req_ready !== 1'b1 || bus3.req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b/%b want 1/1", bus1.req_ready, bus3.req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t tbl[$];
    logic [31:0] r;
    logic e;
    tbl.push_back(vec_t'{32'h10,   32'h8899AABB, 4'b1111, 3'd0, 32'h0,        1'b0});
    tbl.push_back(vec_t'{32'h10,   32'h0,        4'b0000, 3'd1, 32'h8899AABB, 1'b0});
    tbl.push_back(vec_t'{32'h12,   32'h00770000, 4'b0100, 3'd0, 32'h0,        1'b0});
    tbl.push_back(vec_t'{32'h12,   32'h0,        4'b0000, 3'd4, 32'h00000077, 1'b0});
    tbl.push_back(vec_t'{32'h13,   32'h0,        4'b0000, 3'd5, 32'h00000088, 1'b0});
    tbl.push_back(vec_t'{32'h13,   32'h0,        4'b0000, 3'd4, 32'hFFFFFF88, 1'b0});
    tbl.push_back(vec_t'{32'h12,   32'h0,        4'b0000, 3'd2, 32'hFFFF8877, 1'b0});
    tbl.push_back(vec_t'{32'h12,   32'h0,        4'b0000, 3'd3, 32'h00008877, 1'b0});
    tbl.push_back(vec_t'{32'h10,   32'h0,        4'b0000, 3'd2, 32'hFFFFAABB, 1'b0});
    tbl.push_back(vec_t'{32'h11,   32'h0,        4'b0000, 3'd1, 32'h0,        1'b1});
    tbl.push_back(vec_t'{32'h13,   32'h12345678, 4'b0011, 3'd0, 32'h0,        1'b1});
    tbl.push_back(vec_t'{32'h10,   32'h0,        4'b0000, 3'd1, 32'h8877AABB, 1'b0});
    tbl.push_back(vec_t'{32'h3000, 32'h0,        4'b0000, 3'd1, 32'h0,        1'b1});
    tbl.push_back(vec_t'{32'h10,   32'h0,        4'b0000, 3'd6, 32'h0,        1'b0});
    tbl.push_back(vec_t'{32'h2FFC, 32'h13572468, 4'b1111, 3'd1, 32'h0,        1'b0});
    tbl.push_back(vec_t'{32'h2FFC, 32'h0,        4'b0000, 3'd1, 32'h13572468, 1'b0});
    tbl.push_back(vec_t'{32'h3000, 32'hFFFFFFFF, 4'b0001, 3'd0, 32'h0,        1'b1});
    foreach (tbl[i]) begin
      txn(1, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].sel, r, e);
      checks++;
      if (r !== tbl[i].er || e !== tbl[i].ee) begin
        errors++;
        $display("FAIL directed[%0d] addr=%h: rdata=%h err=%b want %h/%b", i, tbl[i].a, r, e, tbl[i].er, tbl[i].ee);
      end
    end
  endtask

  task automatic test_lat3_throughput();
    longint acc[$];
    longint rsp[$];
    drive(3, 1'b1, 32'h0, 32'h0, 4'h0, 3'd0);
    for (int i = 0; i < 30; i++) begin
      if (bus3.req_ready === 1'b1) acc.push_back(cyc + 1);
      if (bus3.rsp_valid === 1'b1) rsp.push_back(cyc);
      @(posedge clk); #1;
    end
    drive(3, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (acc.size() < 7 || rsp.size() < 6) begin
      errors++; $display("FAIL lat3_counts: accepts=%0d rsps=%0d want >=7/>=6", acc.size(), rsp.size());
    end
    for (int i = 0; i + 1 < acc.size(); i++) begin
      checks++;
      if (acc[i+1] - acc[i] != 4) begin
        errors++; $display("FAIL lat3_spacing[%0d]: got %0d want 4", i, acc[i+1] - acc[i]);
      end
    end
    for (int i = 0; i < rsp.size(); i++) begin
      checks++;
      if (i >= acc.size() || rsp[i] != acc[i] + 2) begin
        errors++; $display("FAIL lat3_rsp_edge[%0d]: got %0d want %0d", i, rsp[i], (i < acc.size()) ? acc[i] + 2 : -1);
      end
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] r;
    logic e;
    int seen = 0;
    txn(3, 32'h20, 32'hCAFEF00D, 4'b1111, 3'd0, r, e);
    txn(3, 32'h20, 32'h0, 4'b0000, 3'd1, r, e);
    drive(3, 1'b1, 32'h20, 32'h0, 4'b0000, 3'd1);
    @(posedge clk); #1;
    drive(3, 1'b0, 32'h20, 32'h0, 4'b0000, 3'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus3.rsp_valid !== 1'b0 || bus3.rsp_rdata !== 32'h0 || bus3.rsp_err !== 1'b0) begin
      errors++; $display("FAIL busy_reset_outputs: valid=%b rdata=%h err=%b want 0/0/0", bus3.rsp_valid, bus3.rsp_rdata, bus3.rsp_err);
    end
    reset = 1'b0;
    m1.delete();
    m3.delete();
    #1;
    checks++;
    if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL busy_reset_ready: got %b want 1", bus3.req_ready); end
    for (int i = 0; i < 5; i++) begin
      if (bus3.rsp_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL dropped_rsp: got %0d pulses want 0", seen); end
    txn(3, 32'h20, 32'h0, 4'b0000, 3'd1, r, e);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL cleared_word: got %h want 00000000", r); end
  endtask

  task automatic test_random(input int d, input int n);
    logic [3:0] legal [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int lim = 4 * ((d == 1) ? D1 : D3);
    logic [31:0] a, r;
    logic [3:0] be;
    logic e;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'(lim) + 32'($urandom_range(0, 63));
        1:       a = 32'(lim - 4) + 32'($urandom_range(0, 3));
        2:       a = $urandom;
        default: a = 32'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 2) == 0)      be = 4'b0000;
      else if ($urandom_range(0, 3) == 0) be = 4'($urandom);
      else                                be = legal[$urandom_range(0, 6)];
      txn(d, a, $urandom, be, 3'($urandom_range(0, 7)), r, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_lat3_throughput();
    test_reset_busy();
    test_random(1, 150);
    test_random(3, 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_responder.md
# dm_responder

Memory-stage data-memory responder: the memory end of the store-byte-enable / load-select interface driven by the pipeline's M stage. It accepts one request at a time, commits byte-enabled stores into an internal word array, and returns loads already lane-extracted and sign- or zero-extended. Response latency is programmable to model wait states. Requests to illegal addresses or with illegal alignment are flagged instead of being executed.

## Interface
Parameters:
- DEPTH, 3072, number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- LAT, 1, cycles from acceptance to response cycle; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; a request is accepted when req_valid && req_ready at a rising edge.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, already placed in byte lanes (lane i = bits 8i+7:8i).
- req_byteEn  in  4  store byte enables; nonzero marks the request as a store.
- req_sel_ld  in  3  load type: 0 none, 1 lw, 2 lh, 3 lhu, 4 lb, 5 lbu; 6 and 7 are treated as none.
- rsp_valid  out  1  one-cycle pulse marking the response.
- rsp_rdata  out  32  extended load data; 0 for stores, errors and nops.
- rsp_err  out  1  request rejected (range or alignment); valid with rsp_valid.

## Operation
- Classification at acceptance:
  - store if req_byteEn != 0; req_sel_ld is then ignored;
  - else load if req_sel_ld is 1..5;
  - else nop. A nop is accepted, gets a normal response, and has rsp_err=0 and rsp_rdata=0.
- Word index is req_addr[31:2]. Range error if req_addr >= 4*DEPTH.
- Store legality:
  - byteEn must be one of 1111, 0011, 1100, 0001, 0010, 0100, 1000, and must match the address.
  - Match means: 1111 with addr[1:0]=00; 0011 or 1100 with addr[1]=byteEn[2] and addr[0]=0; single-lane with lane index = addr[1:0].
  - Any mismatch or range error sets err and suppresses the write.
  - A legal store writes only the enabled lanes.
- Load legality: lw needs addr[1:0]=00; lh/lhu need addr[0]=0; lb/lbu need nothing. An illegal load or range error sets err and rdata=0.
- Load extraction from word W:
  - lw = W;
  - lh/lhu use half = addr[1] ? W[31:16] : W[15:0]; lh sign-extends bit 15, lhu zero-extends;
  - lb/lbu use byte lane addr[1:0]; lb sign-extends bit 7, lbu zero-extends.
- Array contents are cleared to 0 on reset.
- FSM:
  - IDLE (req_ready=1). On accept go to BUSY, with cnt = LAT-1, rsp_rdata and rsp_err computed and registered, and the store committed.
  - BUSY (req_ready=0). rsp_valid = (cnt==0). On the edge where cnt==0, go to IDLE; otherwise cnt decrements.

## Timing
- Reset values: state IDLE, cnt 0, rsp_valid 0, rsp_rdata 0, rsp_err 0. req_ready is 0 while reset is high and 1 in the first cycle after reset falls.
- Accept at edge E0; rsp_valid is high exactly in the cycle between edges E(LAT-1) and E(LAT), i.e. LAT cycles after acceptance for LAT=1.
- rsp_rdata and rsp_err are stable from E0 through the response cycle, and hold their values until the next acceptance.
- Throughput: one request per LAT+1 cycles. req_ready is low for LAT cycles after each acceptance.
- A load reads the array before a same-edge store could update it. Because requests are serialized, there is never a same-edge store and load; a load always sees all previously accepted stores.
- A store commit is visible to the next accepted request.
- Reset while BUSY: the in-flight response is dropped, rsp_valid stays 0, and the outputs return to reset values on that edge. A store already committed at E0 is then cleared by the array reset.
- req_valid asserted while BUSY is ignored, not queued.
- Requests with req_addr >= 4*DEPTH never alias into the array.

## Test plan
- LAT=1, sw addr 0x10 data 0x8899AABB, then lw 0x10 -> rsp_valid one cycle after each accept; load rdata 0x8899AABB, err 0; req_ready low only during each response cycle.
- After the sw above, sb byteEn 0100 addr 0x12 data 0x00770000, then lb 0x12 -> 0x00000077; lbu 0x13 -> 0x00000088; lb 0x13 -> 0xFFFFFF88.
- lh 0x12 -> 0xFFFF8877; lhu 0x12 -> 0x00008877; lh 0x10 -> 0xFFFFAABB.
- Errors:
  - lw 0x11 -> err 1, rdata 0;
  - sh byteEn 0011 addr 0x13 -> err 1, and a later lw 0x10 shows an unchanged word;
  - lw 4*DEPTH -> err 1;
  - sel_ld=6 with byteEn=0 -> nop, err 0, rdata 0.
- LAT=3: accept at edge E0 -> rsp_valid high only between E2 and E3; req_valid held continuously yields accepts exactly every 4 cycles.
- Reset pulsed the cycle after accepting lw with LAT=3 -> no rsp_valid; req_ready=1 after reset falls; a subsequent lw of the same address returns 0.
